// File: rtl/microondas_controle.sv
// Microwave cook controller: mm:ss keypad entry, load/enable/clear of the external BCD countdown chain.
// Optional quick start (preset QUICK_TIME on start with no entry) is built when QUICK_START_EN is defined.
module microondas_controle #(
    parameter int          DONE_CYCLES = 3
`ifdef QUICK_START_EN
    ,
    parameter logic [15:0] QUICK_TIME  = 16'h0030
`endif
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    input  logic        sec_tick,
    input  logic        timer_zero,
    output logic [15:0] load_time,
    output logic        timer_loadn,
    output logic        timer_en,
    output logic        timer_clearn,
    output logic        magnetron_on,
    output logic        done,
    output logic [2:0]  state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SET   = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_COOK  = 3'd3;
    localparam logic [2:0] ST_PAUSE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int            CW        = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [CW-1:0] DONE_LAST = CW'(DONE_CYCLES - 1);

    logic [2:0]    state_reg, state_next;
    logic [15:0]   load_time_reg, load_time_next;
    logic          clearn_reg, clearn_next;
    logic [CW-1:0] done_cnt_reg, done_cnt_next;

    logic [3:0] nibble_gt5;
    logic       key_ok;
    logic       time_zero;
    logic       start_go;

    // Tens digits (s10, m10) may only receive a value 0..5 after the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nibble
            assign nibble_gt5[gi] = (load_time_reg[4*gi +: 4] > 4'd5);
        end
    endgenerate

    assign key_ok    = key_valid & (key_digit <= 4'd9) & ~nibble_gt5[0] & ~nibble_gt5[2];
    assign time_zero = (load_time_reg == 16'h0000);
    assign start_go  = start & door_closed;

    always_comb begin
        state_next     = state_reg;
        load_time_next = load_time_reg;
        clearn_next    = 1'b1;
        done_cnt_next  = done_cnt_reg;
        case (state_reg)
            ST_IDLE, ST_SET: begin
                if (stop_clear) begin
                    load_time_next = 16'h0000;
                    state_next     = ST_IDLE;
                end else if (start_go && !time_zero) begin
                    state_next = ST_LOAD;
`ifdef QUICK_START_EN
                end else if (start_go) begin
                    load_time_next = QUICK_TIME;
                    state_next     = ST_LOAD;
`endif
                end else if (key_ok) begin
                    load_time_next = {load_time_reg[11:0], key_digit};
                    state_next     = ST_SET;
                end
            end
            ST_LOAD: begin
                state_next = ST_COOK;
            end
            ST_COOK: begin
                // Reaching 00:00 takes precedence over a simultaneous pause.
                if (timer_zero) begin
                    state_next    = ST_DONE;
                    done_cnt_next = '0;
                end else if (stop_clear || !door_closed) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (stop_clear) begin
                    state_next     = ST_IDLE;
                    load_time_next = 16'h0000;
                    clearn_next    = 1'b0;
                end else if (start_go) begin
                    state_next = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop_clear || (done_cnt_reg == DONE_LAST)) begin
                    state_next     = ST_IDLE;
                    load_time_next = 16'h0000;
                    clearn_next    = 1'b0;
                end else begin
                    done_cnt_next = done_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = ST_IDLE;
                load_time_next = 16'h0000;
                clearn_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg     <= ST_IDLE;
            load_time_reg <= 16'h0000;
            clearn_reg    <= 1'b0;
            done_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            load_time_reg <= load_time_next;
            clearn_reg    <= clearn_next;
            done_cnt_reg  <= done_cnt_next;
        end
    end

    // Enable is combinational with the tick so the chain moves in the tick's own cycle.
    assign timer_en     = (state_reg == ST_COOK) & sec_tick & ~timer_zero;
    assign load_time    = load_time_reg;
    assign timer_loadn  = (state_reg != ST_LOAD);
    assign timer_clearn = clearn_reg;
    assign magnetron_on = (state_reg == ST_COOK);
    assign done         = (state_reg == ST_DONE);
    assign state        = state_reg;

endmodule

// File: tb/tb_microondas_controle.sv
// Randomized scoreboard bench for microondas_controle with a BCD countdown chain model attached.
// The reference model tracks the entry as a decimal mmss number and the chain as whole seconds.
module tb_microondas_controle;

    localparam int DONE_CYCLES = 3;
`ifdef QUICK_START_EN
    localparam bit QUICK = 1'b1;
`else
    localparam bit QUICK = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_LOAD  = 2;
    localparam int M_COOK  = 3;
    localparam int M_PAUSE = 4;
    localparam int M_DONE  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, key_valid, start, stop_clear, door_closed, sec_tick, timer_zero;
    logic [3:0]  key_digit;
    logic [15:0] load_time;
    logic        timer_loadn, timer_en, timer_clearn, magnetron_on, done;
    logic [2:0]  state;

    microondas_controle #(.DONE_CYCLES(DONE_CYCLES)) dut (
        .clk          (clk),
        .clear        (clear),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .start        (start),
        .stop_clear   (stop_clear),
        .door_closed  (door_closed),
        .sec_tick     (sec_tick),
        .timer_zero   (timer_zero),
        .load_time    (load_time),
        .timer_loadn  (timer_loadn),
        .timer_en     (timer_en),
        .timer_clearn (timer_clearn),
        .magnetron_on (magnetron_on),
        .done         (done),
        .state        (state)
    );

    // External mod10/mod6 countdown chain driven by the controller.
    logic [15:0] chain;

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] s1, s10, m1, m10;
        {m10, m1, s10, s1} = v;
        if (s1 != 0) s1 = s1 - 1;
        else begin
            s1 = 4'd9;
            if (s10 != 0) s10 = s10 - 1;
            else begin
                s10 = 4'd5;
                if (m1 != 0) m1 = m1 - 1;
                else begin
                    m1  = 4'd9;
                    m10 = m10 - 1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    always @(posedge clk) begin
        if (!timer_clearn)     chain <= 16'h0000;
        else if (!timer_loadn) chain <= load_time;
        else if (timer_en)     chain <= bcd_dec(chain);
    end
    assign timer_zero = (chain == 16'h0000);

    typedef struct {
        logic [2:0]  st;
        logic [15:0] lt;
        logic        ld;
        logic        en;
        logic        cl;
        logic        mag;
        logic        dn;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc_no = 0;
    int   n_done_seen = 0;

    // Reference model state
    bit   model_on = 1'b0;
    int   m_mode, m_entry, m_secs, m_done_cyc;
    logic m_clearn;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("state",        {13'd0, state},        {13'd0, e.st});
            chk("load_time",    load_time,             e.lt);
            chk("timer_loadn",  {15'd0, timer_loadn},  {15'd0, e.ld});
            chk("timer_en",     {15'd0, timer_en},     {15'd0, e.en});
            chk("timer_clearn", {15'd0, timer_clearn}, {15'd0, e.cl});
            chk("magnetron_on", {15'd0, magnetron_on}, {15'd0, e.mag});
            chk("done",         {15'd0, done},         {15'd0, e.dn});
        end
    end

    // Drive one cycle of inputs, push the expected outputs for it, advance the model.
    task automatic cyc(input logic c, input logic kv, input logic [3:0] kd,
                       input logic st, input logic sc, input logic dc, input logic tk);
        exp_t e;
        bit   zero;
        int   prev;
        clear = c; key_valid = kv; key_digit = kd; start = st;
        stop_clear = sc; door_closed = dc; sec_tick = tk;
        if (model_on) begin
            zero  = (m_secs == 0);
            prev  = m_mode;
            e.st  = 3'(m_mode);
            e.lt  = to_bcd(m_entry);
            e.ld  = (m_mode != M_LOAD);
            e.cl  = m_clearn;
            e.mag = (m_mode == M_COOK);
            e.dn  = (m_mode == M_DONE);
            e.en  = (m_mode == M_COOK) && tk && !zero;
            sb_q.push_back(e);
            if (!e.cl)      m_secs = 0;
            else if (!e.ld) m_secs = (m_entry / 100) * 60 + (m_entry % 100);
            else if (e.en)  m_secs = m_secs - 1;
            if (c) begin
                m_mode = M_IDLE; m_entry = 0; m_clearn = 1'b0; m_done_cyc = 0;
            end else begin
                m_clearn = 1'b1;
                case (m_mode)
                    M_IDLE, M_SET: begin
                        if (sc) begin
                            m_entry = 0; m_mode = M_IDLE;
                        end else if (st && dc && m_entry != 0) begin
                            m_mode = M_LOAD;
                        end else if (QUICK && st && dc) begin
                            m_entry = 30; m_mode = M_LOAD;
                        end else if (kv && kd <= 9 && (m_entry % 10) <= 5 && (m_entry / 100 % 10) <= 5) begin
                            m_entry = (m_entry * 10 + int'(kd)) % 10000;
                            m_mode  = M_SET;
                        end
                    end
                    M_LOAD: m_mode = M_COOK;
                    M_COOK: begin
                        if (zero) begin
                            m_mode = M_DONE; m_done_cyc = 1;
                        end else if (sc || !dc) begin
                            m_mode = M_PAUSE;
                        end
                    end
                    M_PAUSE: begin
                        if (sc) begin
                            m_mode = M_IDLE; m_entry = 0; m_clearn = 1'b0;
                        end else if (st && dc) begin
                            m_mode = M_COOK;
                        end
                    end
                    default: begin
                        if (sc || m_done_cyc >= DONE_CYCLES) begin
                            m_mode = M_IDLE; m_entry = 0; m_clearn = 1'b0;
                        end else begin
                            m_done_cyc++;
                        end
                    end
                endcase
            end
            if (m_mode == M_DONE && prev != M_DONE) n_done_seen++;
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        cyc(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic go();
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic       r_c, r_kv, r_st, r_sc, r_dc, r_tk;
        logic [3:0] r_kd;

        clear = 1'b1; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
        stop_clear = 1'b0; door_closed = 1'b1; sec_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_mode = M_IDLE; m_entry = 0; m_secs = 0; m_done_cyc = 0; m_clearn = 1'b0;
        model_on = 1'b1;

        $display("txn reset: clear held, outputs checked against reset values");
        do_reset();
        idle(2);

        $display("txn 1: keys 1,3,0 then start, 90 ticks to done");
        key(4'd1); key(4'd3); key(4'd0); go();
        for (int i = 0; i < 200; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, logic'(i % 2));

        $display("txn 2: door opens mid-cook, ticks ignored, resume without reload");
        do_reset();
        key(4'd2); key(4'd0); go();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)  cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("txn 3: digit range and tens-digit rejection");
        do_reset();
        key(4'd7); key(4'd9); idle(1); key(4'd12);
        cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        key(4'd7); key(4'd0); key(4'd0); key(4'd1); idle(2);

        $display("txn 4: start and stop_clear together in SET");
        do_reset();
        key(4'd5);
        cyc(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);

        $display("txn 5: clear asserted mid-cook");
        do_reset();
        key(4'd4); key(4'd5); go();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);

        $display("txn 6: start with zero entry from IDLE and from SET");
        do_reset();
        go();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();
        key(4'd0); go();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("txn random: 20000 randomized cycles");
        do_reset();
        for (int n = 0; n < 20000; n++) begin
            r_c  = ($urandom_range(0, 499) == 0);
            r_sc = ($urandom_range(0, 59) == 0);
            r_dc = ($urandom_range(0, 29) != 0);
            r_st = ($urandom_range(0, 15) == 0);
            r_tk = logic'($urandom_range(0, 1));
            r_kd = 4'($urandom_range(0, 11));
            r_kv = 1'b0;
            if (!r_sc && !r_st && r_dc && m_entry < 10 && $urandom_range(0, 3) == 0) r_kv = 1'b1;
            cyc(r_c, r_kv, r_kd, r_st, r_sc, r_dc, r_tk);
        end
        idle(4);
        $display("txn end: %0d cycles driven, %0d cook completions", cyc_no, n_done_seen);

        chk("scoreboard_drained", 16'(sb_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
